mem_port_arbiter: RTL and testbench

Shares the single external memory port between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage RISC-V pipeline. It serialises accesses through a 3-state FSM and drives a registered variable-latency request/acknowledge handshake to the memory. It returns fetched instructions and load data, and produces per-stage stall signals for the hazard logic. MEM has priority; a starvation counter guarantees forward progress of IF.

---
 rtl/riscv_pipe_pkg.sv | 18 +
 rtl/mem_port_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pipe_pkg.sv
// Shared definitions for the 5-stage RISC-V pipeline.
//   arb_state_t : states of the IF/MEM memory-port arbiter
//   ADDR_W      : byte-address width (PC width)
//   DATA_W      : memory word / register width
//   INSTR_W     : instruction width
package riscv_pipe_pkg;

  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 64;
  localparam int INSTR_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single external memory port between the IF
// stage (instruction fetch) and the MEM stage (load/store).
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   if_req/if_addr  fetch request, held until if_valid
//   if_rdata        fetched instruction, valid with the one-cycle if_valid
//   mem_req/mem_we/mem_addr/mem_wdata
//                   load/store request, held until mem_done
//   mem_rdata       load data, valid with the one-cycle mem_done
//   stall_if        if_req && !if_valid
//   stall_mem       mem_req && !mem_done
//   ext_req/ext_we/ext_addr/ext_wdata
//                   registered request to memory, stable until ext_ack
//   ext_ack/ext_rdata
//                   one-cycle completion (and read data) from memory
//   dbg_state       current arbiter state, for observation only
//
// Memory handshake: ext_req rises on the edge that leaves IDLE and the
// request fields stay constant while ext_req is high. The memory may take
// any number of cycles and answers with a single-cycle ext_ack; the edge
// that samples ext_ack drops ext_req and returns to IDLE. ext_ack while no
// request is outstanding has no effect.
//
// Arbitration: MEM wins a tie unless IF has already lost STARVE_LIM
// consecutive grants to MEM while waiting, in which case IF is forced.
module mem_port_arbiter #(
  parameter int ADDR_W     = riscv_pipe_pkg::ADDR_W,
  parameter int DATA_W     = riscv_pipe_pkg::DATA_W,
  parameter int INSTR_W    = riscv_pipe_pkg::INSTR_W,
  parameter int STARVE_LIM = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       if_req,
  input  logic [ADDR_W-1:0]          if_addr,
  output logic [INSTR_W-1:0]         if_rdata,
  output logic                       if_valid,
  input  logic                       mem_req,
  input  logic                       mem_we,
  input  logic [ADDR_W-1:0]          mem_addr,
  input  logic [DATA_W-1:0]          mem_wdata,
  output logic [DATA_W-1:0]          mem_rdata,
  output logic                       mem_done,
  output logic                       stall_if,
  output logic                       stall_mem,
  output logic                       ext_req,
  output logic                       ext_we,
  output logic [ADDR_W-1:0]          ext_addr,
  output logic [DATA_W-1:0]          ext_wdata,
  input  logic                       ext_ack,
  input  logic [DATA_W-1:0]          ext_rdata,
  output riscv_pipe_pkg::arb_state_t dbg_state
);

  import riscv_pipe_pkg::arb_state_t;
  import riscv_pipe_pkg::IDLE;
  import riscv_pipe_pkg::BUSY_I;
  import riscv_pipe_pkg::BUSY_D;

  localparam int              CNT_W = $clog2(STARVE_LIM + 1);
  localparam logic [CNT_W-1:0] C_LIM = CNT_W'(STARVE_LIM);

  arb_state_t           r_state;
  logic [CNT_W-1:0]     r_starve_cnt;
  logic                 r_ext_req;
  logic                 r_ext_we;
  logic [ADDR_W-1:0]    r_ext_addr;
  logic [DATA_W-1:0]    r_ext_wdata;
  logic [INSTR_W-1:0]   r_if_rdata;
  logic                 r_if_valid;
  logic [DATA_W-1:0]    r_mem_rdata;
  logic                 r_mem_done;

  logic                 w_idle;
  logic                 w_if_forced;
  logic                 w_grant_d;
  logic                 w_grant_i;
  logic [INSTR_W-1:0]   w_fetch_word;

  assign w_idle      = (r_state == IDLE);
  // IF has waited through STARVE_LIM MEM grants: it takes the next slot.
  assign w_if_forced = if_req && (r_starve_cnt == C_LIM);
  assign w_grant_d   = w_idle && mem_req && !w_if_forced;
  assign w_grant_i   = w_idle && !w_grant_d && if_req;

  // A fetch returns one 32-bit half of the 64-bit word. ext_addr still holds
  // the fetch address while BUSY_I, so its bit 2 picks the half even if the
  // IF stage has since moved its PC.
  assign w_fetch_word = r_ext_addr[2] ? ext_rdata[2*INSTR_W-1:INSTR_W]
                                      : ext_rdata[INSTR_W-1:0];

  // FSM, memory request registers and returned data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_ext_req   <= 1'b0;
      r_ext_we    <= 1'b0;
      r_ext_addr  <= '0;
      r_ext_wdata <= '0;
      r_if_rdata  <= '0;
      r_if_valid  <= 1'b0;
      r_mem_rdata <= '0;
      r_mem_done  <= 1'b0;
    end else begin
      // Completion flags are single-cycle pulses.
      r_if_valid <= 1'b0;
      r_mem_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_d) begin
            r_state     <= BUSY_D;
            r_ext_req   <= 1'b1;
            r_ext_we    <= mem_we;
            r_ext_addr  <= mem_addr;
            r_ext_wdata <= mem_wdata;
          end else if (w_grant_i) begin
            r_state     <= BUSY_I;
            r_ext_req   <= 1'b1;
            r_ext_we    <= 1'b0;
            r_ext_addr  <= if_addr;
            r_ext_wdata <= '0;
          end
        end
        BUSY_I: begin
          // Completes even if if_req was dropped meanwhile.
          if (ext_ack) begin
            r_state    <= IDLE;
            r_ext_req  <= 1'b0;
            r_if_rdata <= w_fetch_word;
            r_if_valid <= 1'b1;
          end
        end
        BUSY_D: begin
          if (ext_ack) begin
            r_state    <= IDLE;
            r_ext_req  <= 1'b0;
            r_mem_done <= 1'b1;
            // A store leaves the last load result visible.
            if (!r_ext_we) begin
              r_mem_rdata <= ext_rdata;
            end
          end
        end
        default: begin
          r_state   <= IDLE;
          r_ext_req <= 1'b0;
        end
      endcase
    end
  end

  // Starvation counter: counts MEM grants taken while IF was waiting.
  // It only moves in IDLE; a wait spanning a busy period is still one wait.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starve_cnt <= '0;
    end else if (w_idle) begin
      if (!if_req || w_grant_i) begin
        r_starve_cnt <= '0;
      end else if (w_grant_d && (r_starve_cnt != C_LIM)) begin
        r_starve_cnt <= r_starve_cnt + CNT_W'(1);
      end
    end
  end

  assign if_rdata  = r_if_rdata;
  assign if_valid  = r_if_valid;
  assign mem_rdata = r_mem_rdata;
  assign mem_done  = r_mem_done;
  assign ext_req   = r_ext_req;
  assign ext_we    = r_ext_we;
  assign ext_addr  = r_ext_addr;
  assign ext_wdata = r_ext_wdata;
  assign dbg_state = r_state;

  // Stalls release in the same cycle the completion pulse is seen.
  assign stall_if  = if_req && !r_if_valid;
  assign stall_mem = mem_req && !r_mem_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios followed by a random
// phase. A transaction-level reference model predicts every memory grant
// and every completion; a monitor compares the DUT against those queues.
module tb_mem_port_arbiter;

  localparam int AW  = 12;
  localparam int DW  = 64;
  localparam int IW  = 32;
  localparam int LIM = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          if_req, mem_req, mem_we, ext_ack;
  logic [AW-1:0] if_addr, mem_addr;
  logic [DW-1:0] mem_wdata, ext_rdata;
  logic [IW-1:0] if_rdata;
  logic          if_valid, mem_done, stall_if, stall_mem;
  logic          ext_req, ext_we;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] mem_rdata, ext_wdata;
  riscv_pipe_pkg::arb_state_t dbg_state;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .INSTR_W(IW), .STARVE_LIM(LIM)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_ack(ext_ack), .ext_rdata(ext_rdata),
    .dbg_state(dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_to(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // grant record: {is_d, we, addr, wdata}; done record: {is_d, data}
  logic [1+1+AW+DW-1:0] exp_grant_q[$];
  logic [DW:0]          exp_done_q[$];
  logic                 done_log[$];   // completions seen on the DUT, 1 = MEM

  logic          m_busy, m_is_d, m_we, m_if_done, m_mem_done;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_mem_rdata;
  logic [IW-1:0] m_word;
  int            m_starve;

  initial begin
    m_busy = 0; m_is_d = 0; m_we = 0; m_addr = '0; m_starve = 0;
    m_if_done = 0; m_mem_done = 0; m_mem_rdata = '0; m_word = '0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_busy = 0; m_starve = 0; m_if_done = 0; m_mem_done = 0; m_mem_rdata = '0;
        exp_grant_q.delete();
        exp_done_q.delete();
      end else begin
        m_if_done  = 0;
        m_mem_done = 0;
        if (m_busy) begin
          if (ext_ack) begin
            m_busy = 0;
            if (m_is_d) begin
              m_mem_done = 1;
              if (!m_we) m_mem_rdata = ext_rdata;
              exp_done_q.push_back({1'b1, m_mem_rdata});
            end else begin
              m_if_done = 1;
              m_word = m_addr[2] ? ext_rdata[63:32] : ext_rdata[31:0];
              exp_done_q.push_back({1'b0, 32'h0, m_word});
            end
          end
        end else begin
          if (!if_req) m_starve = 0;
          if (mem_req && !(if_req && m_starve == LIM)) begin
            m_busy = 1; m_is_d = 1; m_we = mem_we; m_addr = mem_addr;
            exp_grant_q.push_back({1'b1, mem_we, mem_addr, mem_wdata});
            if (if_req && m_starve < LIM) m_starve++;
          end else if (if_req) begin
            m_busy = 1; m_is_d = 0; m_we = 0; m_addr = if_addr;
            exp_grant_q.push_back({1'b0, 1'b0, if_addr, 64'h0});
            m_starve = 0;
          end
        end
      end
    end
  end

  // ---------------- memory responder ----------------
  int            force_delay;   // <0: random 0..3 wait cycles
  logic          fixed_en;
  logic [DW-1:0] fixed_rdata;
  logic          spur_req;
  logic          r_active;
  int            r_cnt;

  initial begin
    ext_ack = 0; ext_rdata = '0; r_active = 0; r_cnt = 0;
    forever begin
      tick();
      if (!rst) begin
        ext_ack = 0; r_active = 0;
      end else if (ext_ack) begin
        ext_ack = 0; r_active = 0;
      end else if (ext_req) begin
        if (!r_active) begin
          r_active = 1;
          r_cnt = (force_delay >= 0) ? force_delay : $urandom_range(0, 3);
        end
        if (r_cnt == 0) begin
          ext_ack = 1;
          ext_rdata = fixed_en ? fixed_rdata : {$urandom, $urandom};
        end else begin
          r_cnt--;
        end
      end else if (spur_req) begin
        spur_req = 0;
        ext_ack = 1;
        ext_rdata = {$urandom, $urandom};
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic                 prev_req;
  logic [1+1+AW+DW-1:0] mon_g;
  logic [DW:0]          mon_d;

  initial begin
    prev_req = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_req = 0;
      end else begin
        chk("ext_req_busy", ext_req, m_busy);
        chk("state_busy", dbg_state != riscv_pipe_pkg::IDLE, m_busy);
        if (ext_req && !prev_req) begin
          if (exp_grant_q.size() == 0) begin
            chk("grant_unexpected", 1'b1, 1'b0);
          end else begin
            mon_g = exp_grant_q.pop_front();
            chk("grant_we", ext_we, mon_g[AW+DW]);
            chk("grant_addr", ext_addr, mon_g[AW+DW-1:DW]);
            chk("grant_wdata", ext_wdata, mon_g[DW-1:0]);
          end
        end
        prev_req = ext_req;
        chk("if_valid_pulse", if_valid, m_if_done);
        chk("mem_done_pulse", mem_done, m_mem_done);
        chk("stall_if", stall_if, if_req && !m_if_done);
        chk("stall_mem", stall_mem, mem_req && !m_mem_done);
        if (if_valid || mem_done) begin
          done_log.push_back(mem_done);
          if (exp_done_q.size() == 0) begin
            chk("done_unexpected", 1'b1, 1'b0);
          end else begin
            mon_d = exp_done_q.pop_front();
            chk("done_kind", mem_done, mon_d[DW]);
            if (mon_d[DW]) chk("mem_rdata", mem_rdata, mon_d[DW-1:0]);
            else           chk("if_rdata", if_rdata, mon_d[DW-1:0]);
          end
        end
      end
    end
  end

  // ---------------- directed helpers ----------------
  function automatic logic sig_val(input int sel);
    case (sel)
      0:       return if_valid;
      1:       return mem_done;
      default: return ext_req;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input int lim, input string name, output int n);
    n = 0;
    while (!sig_val(sel) && n < lim) begin
      tick();
      n++;
    end
    if (!sig_val(sel)) fail_to(name);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ext_req"},   ext_req,   0);
    chk({tag, "_ext_we"},    ext_we,    0);
    chk({tag, "_ext_addr"},  ext_addr,  0);
    chk({tag, "_ext_wdata"}, ext_wdata, 0);
    chk({tag, "_if_rdata"},  if_rdata,  0);
    chk({tag, "_if_valid"},  if_valid,  0);
    chk({tag, "_mem_rdata"}, mem_rdata, 0);
    chk({tag, "_mem_done"},  mem_done,  0);
    chk({tag, "_state"},     dbg_state, riscv_pipe_pkg::IDLE);
  endtask

  // ---------------- main stimulus ----------------
  logic pat [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  int   n;
  int   cnt;

  initial begin
    rst = 0; if_req = 0; mem_req = 0; mem_we = 0;
    if_addr = '0; mem_addr = '0; mem_wdata = '0;
    force_delay = 0; fixed_en = 0; fixed_rdata = '0; spur_req = 0;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1;
    repeat (2) tick();

    // Single fetch, ack 3 cycles after ext_req, upper half selected.
    force_delay = 3; fixed_en = 1; fixed_rdata = 64'hDEADBEEF_00500093;
    tick();
    if_addr = 12'h004; if_req = 1;
    n = 0;
    while (!if_valid && n < 30) begin
      tick();
      n++;
      if (!if_valid) chk("fetch_stall_wait", stall_if, 1);
    end
    if (!if_valid) fail_to("fetch_valid");
    chk("fetch_latency", n, 5);
    chk("fetch_rdata", if_rdata, 32'hDEADBEEF);
    chk("fetch_stall_done", stall_if, 0);
    if_req = 0;
    cnt = 0;
    repeat (4) begin tick(); cnt += int'(if_valid); end
    chk("fetch_single_pulse", cnt, 0);

    // Conflict: store wins, IF follows after one IDLE cycle.
    force_delay = 0; fixed_en = 0;
    tick();
    if_addr = 12'h010; if_req = 1;
    mem_req = 1; mem_we = 1; mem_addr = 12'h100; mem_wdata = 64'h1234;
    wait_sig(2, 10, "conflict_grant", n);
    chk("conflict_first_we", ext_we, 1);
    chk("conflict_first_addr", ext_addr, 12'h100);
    chk("conflict_first_wdata", ext_wdata, 64'h1234);
    wait_sig(1, 10, "conflict_mem_done", n);
    mem_req = 0; mem_we = 0;
    chk("conflict_idle_gap", ext_req, 0);
    tick();
    chk("conflict_if_req", ext_req, 1);
    chk("conflict_if_we", ext_we, 0);
    chk("conflict_if_addr", ext_addr, 12'h010);
    chk("conflict_if_wdata", ext_wdata, 0);
    wait_sig(0, 10, "conflict_if_valid", n);
    if_req = 0;
    repeat (2) tick();

    // Starvation: 4 MEM grants, then IF, then MEM again.
    done_log.delete();
    mem_we = 0; mem_addr = 12'h040; if_addr = 12'h00C;
    if_req = 1; mem_req = 1;
    n = 0;
    while (done_log.size() < 6 && n < 80) begin
      tick();
      n++;
      if (if_valid) if_req = 0;
    end
    mem_req = 0; if_req = 0;
    if (done_log.size() < 6) fail_to("starve_sequence");
    else for (int i = 0; i < 6; i++) chk($sformatf("starve_order_%0d", i), done_log[i], pat[i]);
    repeat (4) tick();

    // Load data, then a store must leave mem_rdata untouched.
    fixed_en = 1; fixed_rdata = 64'h0123456789ABCDEF;
    mem_we = 0; mem_addr = 12'h018; mem_req = 1;
    wait_sig(1, 20, "load_done", n);
    chk("load_rdata", mem_rdata, 64'h0123456789ABCDEF);
    mem_req = 0;
    tick();
    fixed_rdata = 64'hFFFF0000_FFFF0000;
    mem_we = 1; mem_addr = 12'h020; mem_wdata = 64'hCAFE; mem_req = 1;
    wait_sig(1, 20, "store_done", n);
    chk("store_keeps_rdata", mem_rdata, 64'h0123456789ABCDEF);
    mem_req = 0; mem_we = 0;
    repeat (2) tick();

    // Abandoned fetch still completes; spurious ack in IDLE is ignored.
    fixed_en = 0; force_delay = 4;
    if_addr = 12'h008; if_req = 1;
    wait_sig(2, 10, "abandon_grant", n);
    if_req = 0;
    n = 0;
    while (!if_valid && n < 20) begin
      tick();
      n++;
      if (!if_valid) chk("abandon_req_held", ext_req, 1);
    end
    chk("abandon_valid", if_valid, 1);
    tick();
    spur_req = 1;
    cnt = 0;
    repeat (4) begin tick(); cnt += int'(if_valid) + int'(mem_done) + int'(ext_req); end
    chk("spurious_no_effect", cnt, 0);

    // Reset during BUSY_D with ack withheld.
    force_delay = 1000;
    mem_we = 0; mem_addr = 12'h030; mem_req = 1;
    wait_sig(2, 10, "rst_busy_grant", n);
    repeat (2) tick();
    #2 rst = 0;
    #1;
    check_all_zero("rst_mid");
    tick();
    force_delay = 0;
    rst = 1;
    wait_sig(2, 10, "rst_fresh_req", n);
    chk("rst_fresh_addr", ext_addr, 12'h030);
    wait_sig(1, 10, "rst_fresh_done", n);
    mem_req = 0;
    repeat (2) tick();

    // Random traffic.
    force_delay = -1; fixed_en = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (if_valid || !if_req) begin
        if_req  = ($urandom_range(0, 99) < 40);
        if_addr = AW'($urandom_range(0, 1023) * 4);
      end else if ($urandom_range(0, 99) < 3) begin
        if_req = 0;
      end
      if (mem_done || !mem_req) begin
        mem_req   = ($urandom_range(0, 99) < 50);
        mem_we    = $urandom_range(0, 1) == 1;
        mem_addr  = AW'($urandom_range(0, 511) * 8);
        mem_wdata = {$urandom, $urandom};
      end else if ($urandom_range(0, 99) < 3) begin
        mem_req = 0;
      end
      if (!ext_req && $urandom_range(0, 99) < 4) spur_req = 1;
    end
    if_req = 0; mem_req = 0; spur_req = 0;
    repeat (20) tick();
    chk("drain_grant_q", exp_grant_q.size(), 0);
    chk("drain_done_q", exp_done_q.size(), 0);
    chk("drain_ext_req", ext_req, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
